// File: rtl/bp_coherence_network_src_arbiter.sv
// Round-robin source arbiter feeding one coherence channel src port.
// A single output register decouples requesters from the channel; valid
// is only raised alongside the channel's ready (helpful consumer).
// Optional per-requester credit gating: define BP_NETWORK_SRC_ARB_CREDIT_EN.
module bp_coherence_network_src_arbiter #(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned packet_width_p = 64,
    parameter int unsigned credits_p      = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p*packet_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]                req_v_i,
    output logic [num_req_p-1:0]                req_ready_o,
    input  logic [num_req_p-1:0]                credit_return_i,
    output logic [packet_width_p-1:0]           data_o,
    output logic                                v_o,
    input  logic                                ready_i
);

    localparam int unsigned RW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned SW = RW + 1;

    logic                      full_r, full_d;
    logic [packet_width_p-1:0] data_r, data_d;
    logic [RW-1:0]             rr_r, rr_d;
    logic [num_req_p-1:0]      elig;
    logic                      grant_v;
    logic [RW-1:0]             grant_idx;

`ifdef BP_NETWORK_SRC_ARB_CREDIT_EN
    localparam int unsigned CW = (credits_p + 1 > 1) ? $clog2(credits_p + 1) : 1;
    logic [CW-1:0] cnt_r [num_req_p];

    // Eligible only with a valid packet and at least one credit left.
    always_comb begin
        elig = '0;
        for (int k = 0; k < num_req_p; k++) begin
            elig[k] = req_v_i[k] && (cnt_r[k] != '0);
        end
    end

    // Per-requester credit counters; grant and return together cancel out.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < num_req_p; k++) cnt_r[k] <= CW'(credits_p);
        end else begin
            for (int k = 0; k < num_req_p; k++) begin
                if (req_ready_o[k] && !credit_return_i[k]) begin
                    cnt_r[k] <= cnt_r[k] - 1'b1;
                end else if (!req_ready_o[k] && credit_return_i[k] &&
                             (cnt_r[k] != CW'(credits_p))) begin
                    cnt_r[k] <= cnt_r[k] + 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Flag a credit returned to an already-full counter (it is dropped).
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_req_p; k++) begin
            if (reset_i && credit_return_i[k] && !req_ready_o[k]) begin
                assert (cnt_r[k] != CW'(credits_p))
                else $error("credit overflow on requester %0d", k);
            end
        end
    end
`endif
`else
    // Credit returns are accepted on the port but have no effect here.
    logic unused_credit_return;
    assign unused_credit_return = ^credit_return_i;

    // Without credit gating every valid requester is eligible.
    always_comb begin
        elig = req_v_i;
    end
`endif

    // Round-robin search starting at rr_r; grant only if the register can take it.
    always_comb begin
        logic [2*num_req_p-1:0] elig_rot;
        logic [SW-1:0]          sum;
        logic [SW-1:0]          nxt;
        grant_v   = 1'b0;
        grant_idx = '0;
        sum       = '0;
        nxt       = '0;
        elig_rot  = {elig, elig} >> rr_r;
        if (reset_i && (!full_r || ready_i)) begin
            for (int i = 0; i < num_req_p; i++) begin
                if (!grant_v && elig_rot[i]) begin
                    grant_v = 1'b1;
                    sum     = {1'b0, rr_r} + SW'(i);
                    if (sum >= SW'(num_req_p)) sum = sum - SW'(num_req_p);
                    grant_idx = RW'(sum);
                end
            end
        end
        req_ready_o = '0;
        for (int k = 0; k < num_req_p; k++) begin
            req_ready_o[k] = grant_v && (grant_idx == RW'(k));
        end
        // Next-state of the output register and pointer.
        full_d = full_r && !ready_i;
        data_d = data_r;
        rr_d   = rr_r;
        if (grant_v) begin
            full_d = 1'b1;
            for (int k = 0; k < num_req_p; k++) begin
                if (grant_idx == RW'(k)) begin
                    data_d = req_data_i[k*packet_width_p +: packet_width_p];
                end
            end
            nxt = {1'b0, grant_idx} + SW'(1);
            if (nxt >= SW'(num_req_p)) nxt = '0;
            rr_d = RW'(nxt);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            full_r <= 1'b0;
            data_r <= '0;
            rr_r   <= '0;
        end else begin
            full_r <= full_d;
            data_r <= data_d;
            rr_r   <= rr_d;
        end
    end

    // Valid only together with ready; data zeroed when empty.
    always_comb begin
        v_o    = full_r && ready_i;
        data_o = full_r ? data_r : '0;
    end

endmodule

// File: doc/bp_coherence_network_src_arbiter.md
BP_COHERENCE_NETWORK_SRC_ARBITER -- requirements
Module: bp_coherence_network_src_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of requesters sharing one coherence channel South (src) port.
REQ-002 SHALL have parameter packet_width_p, default 64: packet width, identical to the channel's packet_width_p.
REQ-003 SHALL have parameter credits_p, default 4: maximum outstanding packets per requester.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port reset_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req_data_i, input, num_req_p x packet_width_p: per-requester packet.
REQ-007 SHALL have port req_v_i, input, num_req_p: per-requester valid.
REQ-008 SHALL have port req_ready_o, output, num_req_p: per-requester accept (valid->ready; may depend on req_v_i).
REQ-009 SHALL have port credit_return_i, input, num_req_p: one pulse returns one credit to that requester.
REQ-010 SHALL have port data_o, output, packet_width_p: packet to channel src_data_i.
REQ-011 SHALL have port v_o, output, 1: valid to channel src_v_i.
REQ-012 SHALL have port ready_i, input, 1: channel src_ready_o (ready->valid, helpful consumer).

Function
REQ-013 SHALL hold one output register: full_r and data_r.
REQ-014 SHALL drive v_o = full_r & ready_i, so valid is never raised without ready.
REQ-015 SHALL drive data_o = data_r whenever full_r, and all-zeros otherwise.
REQ-016 SHALL treat requester k as eligible when req_v_i[k] = 1 and (credit feature on) cnt[k] > 0.
REQ-017 SHALL grant at most one eligible requester per cycle, and only when full_r = 0 or ready_i = 1 (drain-and-refill in the same cycle).
REQ-018 SHALL use round-robin priority: search starts at pointer rr_r and ascends modulo num_req_p.
REQ-019 SHALL drive req_ready_o[k] = 1 only for the granted k, and 0 for all others.
REQ-020 SHALL, on a grant to k, set data_r <= req_data_i[k], full_r <= 1, and rr_r <= (k+1) mod num_req_p.
REQ-021 SHALL clear full_r when full_r & ready_i and no grant occurs.
REQ-022 SHALL hold rr_r and data_r when no grant occurs.
REQ-023 SHALL give a latency of one cycle from the accept handshake to v_o, and sustain throughput of one packet per cycle while ready_i = 1.
REQ-024 SHALL never change data_r while full_r & ~ready_i.
REQ-025 SHALL size rr_r at BSG_SAFE_CLOG2(num_req_p) bits; with num_req_p = 1 the pointer stays 0.
REQ-026 SHALL size cnt[k] at BSG_SAFE_CLOG2(credits_p+1) bits.
REQ-027 SHALL update cnt[k] as follows: decrement on grant to k; increment on credit_return_i[k]; hold if both occur in the same cycle.
REQ-028 SHALL ignore a credit return when cnt[k] = credits_p (saturate), and flag this with a simulation-only assertion.

Reset
REQ-029 SHALL, while reset_i = 0 (asynchronous), force full_r = 0, data_r = 0, rr_r = 0, and cnt[k] = credits_p.
REQ-030 SHALL hold v_o = 0 and req_ready_o = 0 during reset.
REQ-031 SHALL discard an in-flight packet on reset assertion, and restore no credit other than the reset value.
REQ-032 SHALL allow the first grant no earlier than the first rising clk_i after reset_i deasserts.

Configuration
REQ-033 SHALL compile in credit gating (cnt[k], credit_return_i use, REQ-016 credit term, REQ-026..028) only when BP_NETWORK_SRC_ARB_CREDIT_EN is defined.
REQ-034 SHALL, without the macro, keep the credit_return_i port but ignore it, treat every requester as having infinite credit, and instantiate no counters.

Verification (num_req_p=3, credits_p=2, packet_width_p=16, macro defined unless stated)
REQ-035 SHALL cover: all req_v_i=3'b111, ready_i=1 for 6 cycles -> grant order 0,1,2,0,1,2 on req_ready_o; data_o sequence follows one cycle later.
REQ-036 SHALL cover: req 0 valid continuously, no credit returns -> exactly 2 accepts, then req_ready_o[0]=0 until credit_return_i[0] pulses, then 1 more accept.
REQ-037 SHALL cover: ready_i=0 with full_r=1 holding 16'hA5A5 for 5 cycles -> v_o=0, data_r unchanged, no req_ready_o; ready_i=1 -> v_o=1 with 16'hA5A5 and a new grant in the same cycle.
REQ-038 SHALL cover: grant to k=1 and credit_return_i[1] in the same cycle with cnt[1]=1 -> cnt[1] stays 1.
REQ-039 SHALL cover: reset_i asserted mid-stream with full_r=1 -> v_o=0 immediately (asynchronous), cnt=2,2,2, rr_r=0 after release.
REQ-040 SHALL cover: macro undefined, req 0 valid for 10 cycles with ready_i=1 -> 10 accepts regardless of credit_return_i.
